// File: rtl/image_select_sync.sv
// image_select_sync: frame-boundary image selection with optional fade-out/swap/fade-in (enable with IMAGE_FADE_EN)
module image_select_sync #(
  parameter int IMG_SIZE    = 19200,
  parameter int ADDR_W      = 17,
  parameter int FADE_FRAMES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        image_index,
  input  logic              frame_start,
  output logic [1:0]        active_index,
  output logic [ADDR_W-1:0] rom_base_addr,
  output logic [3:0]        brightness,
  output logic              busy
);
`ifdef IMAGE_FADE_EN
  localparam int CW = $clog2(FADE_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;
  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [1:0]        target, target_d, active_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        bright_d;
  logic              busy_d, step;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      target        <= '0;
      active_index  <= '0;
      rom_base_addr <= '0;
      brightness    <= 4'd15;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      target        <= target_d;
      active_index  <= active_d;
      rom_base_addr <= addr_d;
      brightness    <= bright_d;
      busy          <= busy_d;
    end
  end
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    target_d = target;
    active_d = active_index;
    addr_d   = rom_base_addr;
    bright_d = brightness;
    busy_d   = busy;
    step     = cnt == CW'(FADE_FRAMES - 1);
    if (frame_start) begin
      case (state)
        IDLE: begin
          if (image_index != active_index) begin
            target_d = image_index;
            busy_d   = 1'b1;
            state_d  = FADE_OUT;
          end
        end
        FADE_OUT: begin
          cnt_d    = step ? '0 : cnt + 1'b1;
          bright_d = step ? brightness - 4'd1 : brightness;
          state_d  = (step && brightness == 4'd1) ? SWAP : FADE_OUT;
        end
        SWAP: begin
          active_d = target;
          addr_d   = ADDR_W'(target) * ADDR_W'(IMG_SIZE);
          state_d  = FADE_IN;
        end
        FADE_IN: begin
          cnt_d    = step ? '0 : cnt + 1'b1;
          bright_d = step ? brightness + 4'd1 : brightness;
          state_d  = (step && brightness == 4'd14) ? IDLE : FADE_IN;
          busy_d   = !(step && brightness == 4'd14);
        end
        default: ;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      active_index  <= '0;
      rom_base_addr <= '0;
    end else if (frame_start && image_index != active_index) begin
      active_index  <= image_index;
      rom_base_addr <= ADDR_W'(image_index) * ADDR_W'(IMG_SIZE);
    end
  end
  assign brightness = 4'd15;
  assign busy       = 1'b0;
`endif
endmodule

// File: doc/image_select_sync.md
# image_select_sync

Consumer of the debounced image index produced by the push-button switch logic. It holds the displayed image selection stable for a whole frame and applies a new selection only at a frame boundary. When the selection changes it fades the picture out, swaps the image ROM base address, and fades back in. It sits between the button/index logic and the VGA pixel pipeline, which multiplies pixel colour by `brightness` and adds `rom_base_addr` to its pixel offset.

## Interface
Parameters:
- `IMG_SIZE`, 19200, image ROM words per image (160x120).
- `ADDR_W`, 17, width of `rom_base_addr`; must satisfy 3*IMG_SIZE < 2^ADDR_W.
- `FADE_FRAMES`, 2, frames spent at each brightness step (>=1).

Ports:
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `image_index`  in  2  requested image, from the button logic; already synchronous to `clk`.
- `frame_start`  in  1  single-cycle pulse at the start of vertical blanking.
- `active_index`  out  2  image currently displayed.
- `rom_base_addr`  out  ADDR_W  active_index*IMG_SIZE.
- `brightness`  out  4  colour scale for the pixel pipeline; 15 = full, 0 = black.
- `busy`  out  1  high while a transition is in progress.

## Operation
- Reset values (all registered): `active_index`=0, `rom_base_addr`=0, `brightness`=15, `busy`=0, state IDLE, frame counter 0, target 0.
- States: IDLE, FADE_OUT, SWAP, FADE_IN.
- IDLE
  - On a `frame_start` cycle with `image_index` != `active_index`: latch `target`=`image_index`, set `busy`=1, go to FADE_OUT. `brightness` stays at 15.
  - Otherwise remain in IDLE.
- FADE_OUT
  - Each `frame_start` increments the frame counter.
  - When the counter equals FADE_FRAMES-1: clear it and decrement `brightness`.
  - The decrement that produces 0 moves the state to SWAP.
- SWAP
  - On the next `frame_start`: `active_index`=`target`, `rom_base_addr`=`target`*IMG_SIZE, go to FADE_IN.
  - `brightness` stays 0 for that frame.
- FADE_IN
  - Counts frames the same way as FADE_OUT, but increments `brightness`.
  - The increment that produces 15 moves the state to IDLE and clears `busy` on the same edge.
- `image_index` changes while `busy`=1 are ignored; `target` is fixed for the whole transition.
- On return to IDLE, a still-mismatched `image_index` starts a new transition at the next `frame_start`.
- Index wrap from 3 to 0 is an ordinary change.
- Arithmetic widths:
  - `brightness` never wraps; it saturates by construction at 0 and 15.
  - `rom_base_addr` product is computed at ADDR_W bits.
- `frame_start` is used as a level each cycle; every high cycle counts as one frame. The source must therefore guarantee a 1-cycle pulse.

## Timing
- All outputs change on the `clk` edge that samples `frame_start`=1; between frame boundaries they never change, except through `reset`.
- Transition length: the start edge F0 plus 30*FADE_FRAMES+1 further `frame_start` pulses.
  - Default FADE_FRAMES=2 gives 61 pulses after F0.
  - `active_index` updates on pulse 15*FADE_FRAMES+1 after F0.
- `reset` asserted mid-transition: all registers take their reset values at that edge. Result is `brightness`=15 and `active_index`=0 immediately, with no fade.
- `reset` and `frame_start` high in the same cycle: `reset` wins.

## Configuration
- `IMAGE_FADE_EN` defined:
  - Full FSM as above.
- `IMAGE_FADE_EN` undefined:
  - FADE_OUT, SWAP and FADE_IN are not built.
  - In IDLE, a `frame_start` with a mismatch updates `active_index` and `rom_base_addr` on that same edge.
  - `brightness` is constant 15 and `busy` is constant 0.

## Test plan
- Reset, then set `image_index`=0 and pulse `frame_start` 5 times -> `busy`=0, `brightness`=15, `active_index`=0 throughout.
- Set `image_index`=2, then pulse `frame_start` (FADE_FRAMES=2):
  - after 30 further pulses, `brightness`=0;
  - after pulse 31, `active_index`=2 and `rom_base_addr`=38400;
  - after pulse 61, `brightness`=15 and `busy`=0.
  - `brightness` is monotonic within each phase.
- During the fade-out of a 0->1 transition, drive `image_index`=3 -> swap lands on 1. The next IDLE `frame_start` starts a 1->3 transition.
- Assert `reset` when `brightness`=7 in FADE_IN -> next cycle `brightness`=15, `active_index`=0, `busy`=0. Further pulses with `image_index`=0 cause no activity.
- `image_index` changes 3->0 (wrap) with `IMAGE_FADE_EN` undefined -> `active_index`=0 and `rom_base_addr`=0 one edge after `frame_start`; `busy` never rises.
